// File: rtl/hazard_stall_unit.sv
// Load-use / ID-branch hazard stall and flush controller for the 5-stage MIPS pipeline.
// Optional saturating stall counter (StallCount) enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_stall_unit #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       IDEX_MemRead,
  input  logic       IDEX_RegWrite,
  input  logic [4:0] IDEXRd,
  input  logic       EXMEM_MemRead,
  input  logic [4:0] EXMEMRd,
  input  logic [4:0] IFIDRs,
  input  logic [4:0] IFIDRt,
  input  logic       ID_UsesRt,
  input  logic       ID_Branch,
  input  logic       ID_BranchTaken,
  input  logic       ID_Jump,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IDEX_Flush,
  output logic       IFID_Flush,
  output logic       Stalling
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] StallCount
`endif
);

  localparam int CW = $clog2(MAX_STALL + 1);

  if (CNT_W < 1 || MAX_STALL < 2) begin : g_bad_param
    $error("hazard_stall_unit: CNT_W must be >= 1 and MAX_STALL >= 2");
  end

  typedef enum logic {IDLE, STALL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] need;
  logic          match_ex, match_mem;
  logic          stall;

  // A source only counts when it is a real register; rs==rt hits collapse to one match.
  assign match_ex  = (IDEXRd != 5'd0) &&
                     ((IDEXRd == IFIDRs) || (ID_UsesRt && (IDEXRd == IFIDRt)));
  assign match_mem = (EXMEMRd != 5'd0) &&
                     ((EXMEMRd == IFIDRs) || (ID_UsesRt && (EXMEMRd == IFIDRt)));

  always_comb begin
    need = '0;
    if (ID_Branch && IDEX_MemRead && match_ex)        need = CW'(2);
    else if (ID_Branch && IDEX_RegWrite && match_ex)  need = CW'(1);
    else if (ID_Branch && EXMEM_MemRead && match_mem) need = CW'(1);
    else if (!ID_Branch && IDEX_MemRead && match_ex)  need = CW'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (state_q == IDLE) begin
      if (need != '0) begin
        stall = 1'b1;
        // Single-cycle stalls stay in IDLE and re-detect with the bubble in EX.
        if (need > CW'(1)) begin
          state_d = STALL;
          cnt_d   = need - CW'(1);
        end
      end
    end else begin
      stall = 1'b1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Branch outcome is only trusted once the stall has released.
  assign Stalling   = stall;
  assign PCWrite    = !stall;
  assign IFIDWrite  = !stall;
  assign IDEX_Flush = stall;
  assign IFID_Flush = rst_n && !stall && (ID_Jump || (ID_Branch && ID_BranchTaken));

`ifdef HAZARD_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: cycle-by-cycle model compare plus literal spot checks.
module tb_hazard_stall_unit;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
  logic [4:0] IDEXRd, EXMEMRd, IFIDRs, IFIDRt;
  logic       ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic       PCWrite, IFIDWrite, IDEX_Flush, IFID_Flush, Stalling;
`ifdef HAZARD_STALL_COUNT_EN
  logic [CW-1:0] StallCount;
`endif

  hazard_stall_unit #(.CNT_W(CW), .MAX_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEXRd(IDEXRd),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEMRd(EXMEMRd),
    .IFIDRs(IFIDRs), .IFIDRt(IFIDRt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Flush(IDEX_Flush),
    .IFID_Flush(IFID_Flush), .Stalling(Stalling)
`ifdef HAZARD_STALL_COUNT_EN
    , .StallCount(StallCount)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles of stall demanded by the ID instruction against what sits in EX / MEM.
  function automatic int need_of();
    bit hit_ex, hit_mem;
    hit_ex  = IDEXRd != 0 && (IDEXRd == IFIDRs || (ID_UsesRt && IDEXRd == IFIDRt));
    hit_mem = EXMEMRd != 0 && (EXMEMRd == IFIDRs || (ID_UsesRt && EXMEMRd == IFIDRt));
    if (ID_Branch && IDEX_MemRead && hit_ex) return 2;
    if (ID_Branch && IDEX_RegWrite && hit_ex) return 1;
    if (ID_Branch && EXMEM_MemRead && hit_mem) return 1;
    if (!ID_Branch && IDEX_MemRead && hit_ex) return 1;
    return 0;
  endfunction

  // Model: remaining stall cycles owed and a saturating count of stall cycles.
  int rem = 0, rem_nx = 0, mcnt = 0, mcnt_nx = 0;
  localparam int MAX_CNT = (1 << CW) - 1;

  always @(negedge clk) begin
    bit e_stall, e_fl;
    int n;
    e_stall = 0;
    e_fl    = 0;
    if (!rst_n) begin
      rem_nx  = 0;
      mcnt_nx = 0;
    end else begin
      if (rem > 0) begin
        e_stall = 1;
        rem_nx  = rem - 1;
      end else begin
        n       = need_of();
        e_stall = (n > 0);
        rem_nx  = (n > 0) ? n - 1 : 0;
      end
      e_fl    = !e_stall && (ID_Jump || (ID_Branch && ID_BranchTaken));
      mcnt_nx = (e_stall && mcnt < MAX_CNT) ? mcnt + 1 : mcnt;
    end
    chk("m_pcwrite",   32'(PCWrite),    32'(!e_stall));
    chk("m_ifidwrite", 32'(IFIDWrite),  32'(!e_stall));
    chk("m_idexflush", 32'(IDEX_Flush), 32'(e_stall));
    chk("m_stalling",  32'(Stalling),   32'(e_stall));
    chk("m_ifidflush", 32'(IFID_Flush), 32'(e_fl));
`ifdef HAZARD_STALL_COUNT_EN
    chk("m_stallcount", 32'(StallCount), 32'(mcnt));
`endif
  end

  always @(posedge clk) begin
    rem  <= rem_nx;
    mcnt <= mcnt_nx;
  end

  task automatic clr();
    IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEXRd = 0;
    EXMEM_MemRead = 0; EXMEMRd = 0;
    IFIDRs = 0; IFIDRt = 0; ID_UsesRt = 0;
    ID_Branch = 0; ID_BranchTaken = 0; ID_Jump = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    clr(); IDEX_MemRead = 1; IDEXRd = 5'd2; IFIDRs = 5'd2;
  endtask

  task automatic branch_load();
    clr(); IDEX_MemRead = 1; IDEXRd = 5'd3; ID_Branch = 1; IFIDRt = 5'd3; ID_UsesRt = 1;
  endtask

  initial begin
    rst_n = 0;
    clr();
    step(); step(); #1;
    chk("rst_pcwrite", 32'(PCWrite), 1);
    chk("rst_stalling", 32'(Stalling), 0);
    chk("rst_idexflush", 32'(IDEX_Flush), 0);
    step(); rst_n = 1; #1;
    chk("idle_stalling", 32'(Stalling), 0);

    // Load-use: exactly one bubble.
    step(); load_use(); #1;
    chk("lu_pcwrite", 32'(PCWrite), 0);
    chk("lu_ifidwrite", 32'(IFIDWrite), 0);
    chk("lu_idexflush", 32'(IDEX_Flush), 1);
    chk("lu_stalling", 32'(Stalling), 1);
    step(); clr(); IFIDRs = 5'd2; #1;
    chk("lu_release", 32'(Stalling), 0);

    // Branch behind a load: two stall cycles, taken outcome ignored until released.
    step(); branch_load(); ID_BranchTaken = 1; #1;
    chk("bl_c1_stall", 32'(Stalling), 1);
    chk("bl_c1_flush", 32'(IFID_Flush), 0);
    step(); IDEX_MemRead = 0; IDEXRd = 0; EXMEM_MemRead = 1; EXMEMRd = 5'd3; #1;
    chk("bl_c2_stall", 32'(Stalling), 1);
    chk("bl_c2_flush", 32'(IFID_Flush), 0);
    step(); EXMEM_MemRead = 0; EXMEMRd = 0; #1;
    chk("bl_c3_flush", 32'(IFID_Flush), 1);
    chk("bl_c3_pcwrite", 32'(PCWrite), 1);
    chk("bl_c3_stall", 32'(Stalling), 0);

    // Register 0 and unused rt never stall; rs==rt counts once.
    step(); clr(); IDEX_MemRead = 1; IDEXRd = 0; IFIDRs = 0; #1;
    chk("r0_nostall", 32'(Stalling), 0);
    step(); IDEXRd = 5'd5; IFIDRs = 5'd1; IFIDRt = 5'd5; ID_UsesRt = 0; #1;
    chk("nort_nostall", 32'(Stalling), 0);
    step(); IFIDRs = 5'd5; ID_UsesRt = 1; #1;
    chk("rsrt_stall", 32'(Stalling), 1);
    step(); clr(); #1;
    chk("rsrt_release", 32'(Stalling), 0);

    // Jump flush.
    step(); ID_Jump = 1; #1;
    chk("j_flush", 32'(IFID_Flush), 1);
    chk("j_pcwrite", 32'(PCWrite), 1);
    chk("j_idexflush", 32'(IDEX_Flush), 0);
    step(); clr(); #1;
    chk("j_after", 32'(IFID_Flush), 0);

    // Branch after ALU op in EX, then after load in MEM: one cycle each.
    step(); ID_Branch = 1; IDEX_RegWrite = 1; IDEXRd = 5'd7; IFIDRs = 5'd7; #1;
    chk("b_alu_stall", 32'(Stalling), 1);
    step(); IDEX_RegWrite = 0; IDEXRd = 0; #1;
    chk("b_alu_release", 32'(Stalling), 0);
    step(); clr(); ID_Branch = 1; EXMEM_MemRead = 1; EXMEMRd = 5'd9; IFIDRt = 5'd9; ID_UsesRt = 1; #1;
    chk("b_mem_stall", 32'(Stalling), 1);
    step(); clr(); #1;
    chk("b_mem_release", 32'(Stalling), 0);

    // Reset in the second cycle of a two-cycle stall aborts it.
    step(); branch_load(); #1;
    chk("rs_c1_stall", 32'(Stalling), 1);
    step(); rst_n = 0; #1;
    chk("rs_forced_stall", 32'(Stalling), 0);
    chk("rs_forced_pcw", 32'(PCWrite), 1);
    step(); clr(); rst_n = 1; #1;
    chk("rs_after", 32'(Stalling), 0);
    step(); #1;
    chk("rs_after2", 32'(Stalling), 0);

    // 1 + 2 + 1 stall cycles, then a long run of load-use stalls to saturate.
    step(); load_use();
    step(); clr();
    step(); branch_load();
    step(); clr();
    step(); load_use();
    step(); clr();
    step(); #1;
`ifdef HAZARD_STALL_COUNT_EN
    chk("cnt_four", 32'(StallCount), 4);
`endif
    step(); load_use();
    repeat (16) step();
    clr();
    step(); #1;
    chk("sat_release", 32'(Stalling), 0);
`ifdef HAZARD_STALL_COUNT_EN
    chk("cnt_sat", 32'(StallCount), MAX_CNT);
`endif
    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
